bomb_lighter: RTL

Countdown-and-detonation controller for the bomb game. It drives the 7-bit LED progress bar (`leds[6:0]`) and the `explosion` flag consumed by the LED output stage, which forces all `LEDR[6:0]` on during an explosion. It arms on a start pulse, lights one more LED per elapsed step, and detonates when the countdown runs out. It stops on a correct defuse and detonates immediately on a wrong wire cut.

---
 rtl/bomb_lighter_pkg.sv | 9 +
 rtl/bomb_lighter_if.sv | 14 +
 rtl/bomb_lighter_step_prescaler.sv | 18 +
 rtl/bomb_lighter.sv | 58 +++++
 4 files changed

// File: rtl/bomb_lighter_pkg.sv
// bomb_pkg: shared state encoding, LED geometry and thermometer decode for the bomb game.
package bomb_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, DEFUSED, EXPLODED} bomb_state_t;
   localparam int NUM_LEDS  = 7;
   localparam int NUM_STEPS = 8;
   function automatic logic [NUM_LEDS-1:0] thermo(input logic [2:0] s);
      for (int i = 0; i < NUM_LEDS; i++) thermo[i] = int'(s) > i;
   endfunction
endpackage

// File: rtl/bomb_lighter_if.sv
// bomb_lighter_if: command pulses in, progress bar and status flags out.
interface bomb_lighter_if;
   import bomb_pkg::*;
   logic                start;
   logic                defuse;
   logic                wrong_cut;
   logic                clear;
   logic [NUM_LEDS-1:0] leds;
   logic                explosion;
   logic                armed;
   logic                defused;
   modport master (output start, defuse, wrong_cut, clear, input leds, explosion, armed, defused);
   modport slave  (input start, defuse, wrong_cut, clear, output leds, explosion, armed, defused);
endinterface

// File: rtl/bomb_lighter_step_prescaler.sv
// step_prescaler: divides clk down to one tick pulse per TICK_DIV running cycles.
module step_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic zero,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV);
   logic [W-1:0] div;
   assign tick = run && div == W'(TICK_DIV - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) div <= '0;
      else if (zero) div <= '0;
      else if (run) div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/bomb_lighter.sv
// bomb_lighter: countdown FSM; outputs are registered from the next state so
// every event shows up on the outputs one edge after it is sampled.
module bomb_lighter
   import bomb_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input logic           clk,
   input logic           rst_n,
   bomb_lighter_if.slave bus
);
   bomb_state_t state, nxt_state;
   logic [2:0]  step, nxt_step;
   logic        tick, run, zero;
   assign run  = state == ARMED && !bus.clear && !bus.wrong_cut && !bus.defuse;
   assign zero = state == IDLE || bus.clear;
   step_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .zero (zero),
      .tick (tick)
   );
   // Priority in ARMED: clear, wrong_cut, defuse, then the countdown tick.
   always_comb begin
      nxt_state = state;
      nxt_step  = step;
      if (state == IDLE) begin
         if (bus.start) nxt_state = ARMED;
      end else if (bus.clear) begin
         nxt_state = IDLE;
         nxt_step  = '0;
      end else if (state == ARMED) begin
         if (bus.wrong_cut) nxt_state = EXPLODED;
         else if (bus.defuse) nxt_state = DEFUSED;
         else if (tick) begin
            if (step == 3'(NUM_STEPS - 1)) nxt_state = EXPLODED;
            else nxt_step = step + 3'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         step          <= '0;
         bus.leds      <= '0;
         bus.explosion <= 1'b0;
         bus.armed     <= 1'b0;
         bus.defused   <= 1'b0;
      end else begin
         state         <= nxt_state;
         step          <= nxt_step;
         bus.leds      <= nxt_state == EXPLODED ? '1 : nxt_state == IDLE ? '0 : thermo(nxt_step);
         bus.explosion <= nxt_state == EXPLODED;
         bus.armed     <= nxt_state == ARMED;
         bus.defused   <= nxt_state == DEFUSED;
      end
endmodule
